// File: rtl/instr_align_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_align_queue_pkg                                                 |
// | Shared constants and handshake structs for the instruction aligner.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package instr_align_queue_pkg;

  localparam logic [31:0] nop_instr = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        rvc;
  } align_queue_out_type;

  typedef struct packed {
    logic        flush;
    logic [31:0] flush_pc;
    logic        ready;
  } align_queue_in_type;

  // A parcel starts a compressed instruction unless its two low bits are 11.
  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_align_queue_parcel_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_align_queue_parcel_ram                                          |
// | DEPTHx16 parcel store: two adjacent write ports, two async reads.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module instr_align_queue_parcel_ram #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     we0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [15:0]              wdata0_i,
  input  logic [15:0]              wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [15:0]              rdata0_o,
  output logic [15:0]              rdata1_o
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] waddr1;
  logic [AW-1:0] raddr1;

  // Power-of-two depth makes the +1 addresses wrap for free.
  assign waddr1   = waddr_i + AW'(1);
  assign raddr1   = raddr_i + AW'(1);
  assign rdata0_o = mem_q[raddr_i];
  assign rdata1_o = mem_q[raddr1];

  always_ff @(posedge clock) begin
    if (we0_i) mem_q[waddr_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1]  <= wdata1_i;
  end

endmodule
`default_nettype wire

// File: rtl/instr_align_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_align_queue                                                     |
// | Aligns 32-bit imem words into 16/32-bit instructions with PCs.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module instr_align_queue
  import instr_align_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        can_fetch,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic        out_rvc
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic          skip_lo_q, skip_lo_d;

  align_queue_in_type  in_s;
  align_queue_out_type out_s;

  logic [15:0] p0, p1;
  logic        is32, push_en, pop, we0, we1;
  logic [15:0] wd0, wd1;
  logic [AW:0] push_n, pop_n;
  logic [31:0] free_w, need_w;

  assign in_s = '{flush: flush, flush_pc: flush_pc, ready: out_ready};

  instr_align_queue_parcel_ram #(.DEPTH(DEPTH)) u_ram (
    .clock    (clock),
    .we0_i    (we0),
    .we1_i    (we1),
    .waddr_i  (wptr_q),
    .wdata0_i (wd0),
    .wdata1_i (wd1),
    .raddr_i  (rptr_q),
    .rdata0_o (p0),
    .rdata1_o (p1)
  );

  // Head decode is purely combinational from the RAM head and registered state.
  always_comb begin
    out_s       = '0;
    is32        = !is_rvc(p0);
    out_s.valid = is32 ? (count_q >= (AW+1)'(2)) : (count_q != '0);
    out_s.rvc   = out_s.valid & ~is32;
    out_s.instr = !out_s.valid ? 32'h0 : (is32 ? {p1, p0} : {16'h0, p0});
    out_s.pc    = head_pc_q;
    out_s.npc   = head_pc_q + ((out_s.valid && is32) ? 32'd4 : 32'd2);
  end

  assign out_valid = out_s.valid;
  assign out_instr = out_s.instr;
  assign out_pc    = out_s.pc;
  assign out_npc   = out_s.npc;
  assign out_rvc   = out_s.rvc;

  // Reserve room for every in-flight word so a push can never overflow.
  always_comb begin
    free_w    = 32'(DEPTH) - 32'(count_q);
    need_w    = (32'(outst_q) + 32'd1) << 1;
    can_fetch = (32'(outst_q) < 32'(MAX_OUT)) && (free_w >= need_w);
  end

  always_comb begin
    outst_d   = outst_q + OW'(imem_req) - OW'(imem_ready);
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    drop_d    = drop_q;
    skip_lo_d = skip_lo_q;

    push_en = imem_ready && !in_s.flush && (drop_q == '0);
    we0     = push_en;
    we1     = push_en && !skip_lo_q;
    wd0     = skip_lo_q ? imem_rdata[31:16] : imem_rdata[15:0];
    wd1     = imem_rdata[31:16];
    push_n  = !push_en ? '0 : (skip_lo_q ? (AW+1)'(1) : (AW+1)'(2));
    pop     = out_s.valid && in_s.ready && !in_s.flush;
    pop_n   = !pop ? '0 : (is32 ? (AW+1)'(2) : (AW+1)'(1));

    if (in_s.flush) begin
      rptr_d    = '0;
      wptr_d    = '0;
      count_d   = '0;
      head_pc_d = in_s.flush_pc & ~32'h1;
      skip_lo_d = in_s.flush_pc[1];
      drop_d    = outst_d;
    end else begin
      rptr_d  = rptr_q + pop_n[AW-1:0];
      wptr_d  = wptr_q + push_n[AW-1:0];
      count_d = count_q + push_n - pop_n;
      if (pop) head_pc_d = out_s.npc;
      if (imem_ready && (drop_q != '0)) drop_d = drop_q - OW'(1);
      if (push_en) skip_lo_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      head_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      skip_lo_q <= 1'b0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      skip_lo_q <= skip_lo_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/instr_align_queue.md
# instr_align_queue

Parametrised instruction buffer between instruction memory and `decode_stage`. It turns 32-bit `imem` response words into a stream of aligned 16/32-bit RISC-V instructions with their PCs, and handles compressed instructions that straddle words and misaligned branch targets. It supports N outstanding fetches and discards responses that are stale after a redirect, which generalises the single-cycle `busy` drop. Decode consumes one instruction per cycle through a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 8: buffer capacity in 16-bit parcels; power of two, ≥4.
- `MAX_OUT`, 2: maximum outstanding `imem` requests; ≥1.
- `RESET_PC`, 32'h0: head PC after reset.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `imem_req` in 1: fetch request accepted by `imem` this cycle.
- `imem_ready` in 1: response word valid this cycle.
- `imem_rdata` in 32: response word, little-endian parcels.
- `can_fetch` out 1: the fetch unit may issue a request this cycle.
- `flush` in 1: redirect (trap, mret, jump, clear).
- `flush_pc` in 32: new head PC, bit 0 ignored.
- `out_valid` out 1: a complete instruction is at the head.
- `out_ready` in 1: decode accepts it (decode not stalled).
- `out_instr` out 32: instruction; upper 16 bits are zero when compressed.
- `out_pc` out 32: PC of `out_instr`.
- `out_npc` out 32: `out_pc` + 2 or + 4.
- `out_rvc` out 1: head instruction is 16-bit.

## Operation
- State:
  - parcel RAM `DEPTH`×16.
  - `rptr` and `wptr`, log2(DEPTH) bits, wrap modulo `DEPTH`.
  - `count`, log2(DEPTH)+1 bits.
  - `head_pc`.
  - `outst`, 0..`MAX_OUT`.
  - `drop`, 0..`MAX_OUT`.
  - `skip_lo`, 1 bit.
- Outstanding tracking: `outst` ← `outst` + `imem_req` − `imem_ready`.
- `can_fetch` = (`outst` < `MAX_OUT`) & (`DEPTH` − `count` ≥ 2·(`outst`+1)). The buffer therefore never overflows.
- Response handling:
  - If `drop` > 0: the word is discarded and `drop` decrements.
  - Else if `skip_lo`: only parcel [31:16] is pushed and `skip_lo` clears.
  - Else: both parcels are pushed, [15:0] first.
- Head decode:
  - Parcel p0 = RAM[`rptr`].
  - p0[1:0] ≠ 2'b11: 16-bit instruction. `out_valid` = `count` ≥ 1.
  - p0[1:0] = 2'b11: 32-bit instruction {RAM[`rptr`+1], p0}. `out_valid` = `count` ≥ 2.
- Pop (`out_valid` & `out_ready`): `rptr` and `count` advance by 1 or 2; `head_pc` ← `out_npc`.
- Simultaneous push and pop: `count` ← `count` + pushed − popped, all in one cycle.
- Flush:
  - `count`, `rptr` and `wptr` are set to 0.
  - `head_pc` ← {`flush_pc`[31:1], 0} and `skip_lo` ← `flush_pc`[1].
  - `drop` ← `outst` + `imem_req` − `imem_ready`, i.e. all requests still in flight after this cycle.
- Flush priority: flush overrides a same-cycle pop and push. A response arriving in the flush cycle is discarded and is not counted in `drop`.
- When `out_valid` = 0, `out_instr`/`out_pc` are don't-care. The bench checks them only under `out_valid`.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_rvc`=0, `out_pc`=`RESET_PC`, `out_npc`=`RESET_PC`+2, `can_fetch`=1. All counters are 0 and `skip_lo`=0.
- Reset mid-operation discards buffer contents and the outstanding/drop state. Responses after reset are pushed normally; the fetch side is reset in the same cycle.
- Latency:
  - `imem_ready` at cycle t → `out_valid` at t+1 (registered push; outputs combinational from the RAM head).
  - A 32-bit instruction split across words becomes valid the cycle after its second word.
- Flush at cycle t: `out_valid`=0 at t+1. The first valid instruction appears the cycle after the first non-dropped response.
- Throughput: one instruction per cycle while `count` suffices. `can_fetch` is combinational from registered state only.

## Structure
- Shared package (`constants`/`wires`):
  - `nop_instr`.
  - An `align_queue_out_type` struct: `valid`, `instr`, `pc`, `npc`, `rvc`.
  - An `align_queue_in_type` struct: `flush`, `flush_pc`, `ready`.
- Natural sub-module: `parcel_ram`, a `DEPTH`×16 RAM with two write ports (pw, pw+1), two async read ports (rptr, rptr+1), and modulo addressing.
- The top level holds pointers, counters, `skip_lo`/`drop` control and head decode.

## Test plan
- **Straight line.** Reset, `RESET_PC`=0x100. Responses 0x00000013, 0x00100093 → two 32-bit instructions at pc 0x100 and 0x104, `out_npc` 0x104 and 0x108, `out_rvc`=0.
- **Compressed mix.** Word 0x00134505 → 0x4505 at pc 0x100 (rvc=1), then a 32-bit instruction straddling into the next word 0x0000xxx0 is held (`out_valid`=0) until that word arrives.
- **Misaligned redirect.** `flush_pc`=0x202, response 0x4581_4501 → only 0x4581 is emitted, at pc 0x202.
- **Stale drop.** `MAX_OUT`=2: two requests issued, flush at t, two responses at t+1 and t+2 → neither is emitted. The third response is emitted.
- **Backpressure/full.** `DEPTH`=8, `out_ready`=0 with continuous fetch → `can_fetch` drops to 0 with `count` ≤ 8, no parcel is overwritten, and the order is preserved after release.
- **Simultaneous events.** Flush, response and pop in the same cycle → no pop, response dropped, `drop` = in-flight count. Reset asserted mid-stream → reset values at the next edge.
